remote_comm: RTL and testbench

- Host-side remote command block for the quadcopter system. It takes a one-byte command plus a 16-bit data word and serializes them over a UART TX line as three bytes.
- It receives a single-byte response (e.g. 0xA5 = ACK) on the UART RX line.
- It sits opposite the flight controller's UART command interface. In simulation it mimics the remote host.

---
 rtl/remote_comm.sv | 211 +++++++++++++++++++++
 tb/tb_remote_comm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - host-side remote command sender (3-byte UART TX) and response receiver (1-byte UART RX)
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  input  logic        clr_resp_rdy
);

  localparam int               CNT_W     = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((BAUD_DIV / 2 > 0) ? (BAUD_DIV / 2 - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    SEND_CMD,
    SEND_HI,
    SEND_LO
  } seq_state_t;

  seq_state_t state;
  logic [15:0] hold_data;

  logic             tx_start;
  logic [7:0]       tx_byte;
  logic [8:0]       tx_shift;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bits;
  logic             tx_busy;
  logic             tx_done;

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             rx_fall;
  logic             rx_start;
  logic             rx_tick;
  logic             rx_done;
  logic             rx_busy;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] rx_target;
  logic [3:0]       rx_bits;
  logic [7:0]       rx_shift;

  // Frame launch request and byte select; the command byte goes straight from
  // the port into the TX shift register, which serves as its holding register.
  always_comb begin
    tx_start = 1'b0;
    tx_byte  = 8'h00;
    case (state)
      IDLE: begin
        tx_start = send_cmd;
        tx_byte  = cmd;
      end
      SEND_CMD: begin
        tx_start = tx_done;
        tx_byte  = hold_data[15:8];
      end
      SEND_HI: begin
        tx_start = tx_done;
        tx_byte  = hold_data[7:0];
      end
      default: begin
        tx_start = 1'b0;
        tx_byte  = 8'h00;
      end
    endcase
  end

  // Command sequencer: walks cmd, data high, data low, then flags completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_data <= 16'h0000;
      cmd_sent  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (send_cmd) begin
            hold_data <= data;
            cmd_sent  <= 1'b0;
            state     <= SEND_CMD;
          end
        end
        SEND_CMD: begin
          if (tx_done) begin
            state <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (tx_done) begin
            state <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (tx_done) begin
            cmd_sent <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Transmitter: start bit is driven at load, then the remaining 9 bits
  // (data LSB first, stop) shift out one per BAUD_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TX       <= 1'b1;
      tx_shift <= 9'h1FF;
      tx_cnt   <= '0;
      tx_bits  <= 4'd0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_start) begin
        TX       <= 1'b0;
        tx_shift <= {1'b1, tx_byte};
        tx_cnt   <= '0;
        tx_bits  <= 4'd0;
        tx_busy  <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt == BAUD_LAST) begin
          tx_cnt <= '0;
          if (tx_bits == 4'd9) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            TX      <= 1'b1;
          end else begin
            TX       <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_bits  <= tx_bits + 4'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  // RX synchronizer: two flops against metastability, third for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall   = rx_prev & ~rx_sync;
  assign rx_start  = ~rx_busy & rx_fall;
  assign rx_target = (rx_bits == 4'd0) ? HALF_LAST : BAUD_LAST;
  assign rx_tick   = rx_busy & (rx_cnt == rx_target);
  assign rx_done   = rx_tick & (rx_bits == 4'd9);

  // Receiver: half a bit to the start-bit centre, then one sample per bit;
  // the stop-bit sample publishes the byte without checking its level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bits  <= 4'd0;
      rx_shift <= 8'h00;
      resp     <= 8'h00;
    end else if (rx_start) begin
      rx_busy <= 1'b1;
      rx_cnt  <= '0;
      rx_bits <= 4'd0;
    end else if (rx_busy) begin
      if (rx_tick) begin
        rx_cnt  <= '0;
        rx_bits <= rx_bits + 4'd1;
        if (rx_bits >= 4'd1 && rx_bits <= 4'd8) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
        end
        if (rx_done) begin
          rx_busy <= 1'b0;
          resp    <= rx_shift;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  // Response-ready flag: a completing frame beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdy <= 1'b0;
    end else if (rx_done) begin
      resp_rdy <= 1'b1;
    end else if (clr_resp_rdy || rx_start) begin
      resp_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - self-checking bench for remote_comm with a TX frame decoder and RX controller model
module tb_remote_comm;
  localparam int B = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        send_cmd = 1'b0;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        clr_resp_rdy = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes the line must carry, and whether a command is in flight.
  logic [7:0] exp_q[$];
  bit         model_idle = 1'b1;

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .clr_resp_rdy(clr_resp_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse send_cmd for one cycle; returns at the negedge after it was sampled.
  task automatic issue(input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    cmd = c;
    data = d;
    send_cmd = 1'b1;
    if (model_idle) begin
      exp_q.push_back(c);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
      model_idle = 1'b0;
    end
    @(negedge clk);
    send_cmd = 1'b0;
    cmd = 8'($urandom);
    data = 16'($urandom);
  endtask

  // Compare one frame cycle-by-cycle against the ideal 8N1 waveform.
  task automatic capture_frame(input string tag, input int lim, output int gap);
    int bad;
    logic [9:0] fr;
    logic [7:0] got;
    logic [7:0] exp;
    bad = 0;
    gap = 0;
    got = 8'h00;
    check({tag, "_queued"}, 32'(exp_q.size() > 0), 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    while (TX !== 1'b0 && gap < lim) begin
      @(negedge clk);
      gap++;
    end
    check({tag, "_start"}, 32'(TX), 0);
    fr = {1'b1, exp, 1'b0};
    for (int i = 0; i < 10 * B; i++) begin
      if (TX !== fr[i / B]) bad++;
      if ((i % B) == B / 2 && (i / B) >= 1 && (i / B) <= 8) got[(i / B) - 1] = TX;
      @(negedge clk);
    end
    check({tag, "_shape"}, 32'(bad), 0);
    check({tag, "_byte"}, 32'(got), 32'(exp));
  endtask

  task automatic wait_sent(input string tag);
    int waited;
    waited = 0;
    while (cmd_sent !== 1'b1 && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_cmd_sent"}, 32'(cmd_sent), 1);
    model_idle = 1'b1;
  endtask

  task automatic run_cmd(input string tag);
    int g0, g1, g2;
    capture_frame({tag, "_b0"}, 0, g0);
    check({tag, "_sent_low"}, 32'(cmd_sent), 0);
    capture_frame({tag, "_b1"}, 3, g1);
    capture_frame({tag, "_b2"}, 3, g2);
    check({tag, "_gap"}, 32'((g1 + g2) <= 3), 1);
    wait_sent(tag);
  endtask

  // Controller model: drive one 8N1 byte on RX, each bit B clocks.
  task automatic drive_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 RX = fr[i];
      repeat (B - 1) @(posedge clk);
    end
  endtask

  // Hold clear high until the frame completes; resp_rdy must still rise.
  task automatic clr_watch();
    int waited;
    waited = 0;
    repeat (2 * B) @(negedge clk);
    clr_resp_rdy = 1'b1;
    while (resp_rdy !== 1'b1 && waited < 12 * B) begin
      @(negedge clk);
      waited++;
    end
    clr_resp_rdy = 1'b0;
    check("set_wins_over_clr", 32'(resp_rdy), 1);
  endtask

  task automatic idle_window(input string tag, input logic exp_sent);
    int tx_bad, sent_bad;
    tx_bad = 0;
    sent_bad = 0;
    for (int i = 0; i < 10 * B; i++) begin
      @(negedge clk);
      if (TX !== 1'b1) tx_bad++;
      if (cmd_sent !== exp_sent) sent_bad++;
    end
    check({tag, "_tx_idle"}, 32'(tx_bad), 0);
    check({tag, "_sent_hold"}, 32'(sent_bad), 0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, r;
    logic [15:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX), 1);
    check("rst_cmd_sent", 32'(cmd_sent), 0);
    check("rst_resp_rdy", 32'(resp_rdy), 0);
    check("rst_resp", 32'(resp), 0);
    rst_n = 1'b1;
    idle_window("idle", 1'b0);

    // Basic command 05 / 00FF, then controller answers A5
    issue(8'h05, 16'h00FF);
    run_cmd("c1");
    drive_rx(8'hA5);
    repeat (2) @(negedge clk);
    check("ack_rdy", 32'(resp_rdy), 1);
    check("ack_resp", 32'(resp), 32'h A5);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    @(negedge clk);
    check("clr_rdy", 32'(resp_rdy), 0);
    check("clr_resp_kept", 32'(resp), 32'h A5);

    // Second send_cmd while busy is ignored
    c = 8'($urandom);
    d = 16'($urandom);
    issue(c, d);
    fork
      run_cmd("c2");
      begin
        repeat (3 * B) @(negedge clk);
        issue(8'h02, 16'h0100);
      end
    join
    idle_window("ignored", 1'b1);
    issue(8'h02, 16'h0100);
    check("c3_sent_cleared", 32'(cmd_sent), 0);
    run_cmd("c3");

    // Response arrives mid-command with clear in the completion cycle
    issue(8'($urandom), 16'($urandom));
    fork
      run_cmd("c4");
      begin
        repeat (4 * B) @(negedge clk);
        fork
          drive_rx(8'h3C);
          clr_watch();
        join
      end
    join
    repeat (3) @(negedge clk);
    check("mid_rdy", 32'(resp_rdy), 1);
    check("mid_resp", 32'(resp), 32'h3C);

    // Reset in the middle of the data-high byte
    d = {8'h00, 8'($urandom)};
    issue(8'($urandom), d);
    begin
      int g;
      capture_frame("c5_b0", 0, g);
    end
    repeat (1 + 3 * B + B / 2) @(negedge clk);
    check("c5_pre_rst_tx", 32'(TX), 0);
    #2 rst_n = 1'b0;
    #1;
    check("c5_rst_tx", 32'(TX), 1);
    check("c5_rst_sent", 32'(cmd_sent), 0);
    check("c5_rst_resp", 32'(resp), 0);
    exp_q.delete();
    model_idle = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(8'($urandom), 16'($urandom));
    run_cmd("c6");
    r = 8'($urandom);
    drive_rx(r);
    repeat (2) @(negedge clk);
    check("c6_resp", 32'(resp), 32'(r));
    check("c6_rdy", 32'(resp_rdy), 1);

    // Randomized commands and responses; a new start bit clears resp_rdy
    for (int k = 0; k < 3; k++) begin
      issue(8'($urandom), 16'($urandom));
      run_cmd($sformatf("rnd%0d", k));
      r = 8'($urandom);
      fork
        drive_rx(r);
        begin
          repeat (5 * B) @(negedge clk);
          check($sformatf("rnd%0d_rdy_cleared", k), 32'(resp_rdy), 0);
        end
      join
      repeat (2) @(negedge clk);
      check($sformatf("rnd%0d_resp", k), 32'(resp), 32'(r));
      check($sformatf("rnd%0d_rdy", k), 32'(resp_rdy), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
